// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared definitions for the stopwatch front-end control.
//   state_e                 - FSM state encoding (IDLE/RUN/PAUSE)
//   DEF_DEBOUNCE_CYCLES     - default debounce length (cycles)
//   DEF_TICK_DIV            - default clk cycles per count step
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TICK_DIV        = 10;

endpackage

// File: rtl/stopwatch_button_debounce.sv
// button_debounce: 2-flop synchroniser, debounce counter and press detector
// for one raw pushbutton.
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset
//   btn_raw  - asynchronous raw button level, active-high
//   press    - one-cycle pulse on the rising edge of the debounced level
import stopwatch_pkg::*;

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          stable_prev_q;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            // Flip on the last of DEBOUNCE_CYCLES consecutive differing cycles.
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
        end
    end

    // Releases (falling edges of stable) produce nothing.
    assign press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front-end, IDLE/RUN/PAUSE FSM and count-rate
// prescaler driving the single-digit stopwatch counter.
//   clk, reset    - clock and synchronous active-high reset
//   btn_start     - raw start/resume button
//   btn_stop      - raw stop (pause) button
//   btn_clear     - raw clear button
//   start_resume  - one-cycle count-step pulse, once per TICK_DIV in RUN
//   stop          - high while paused
//   clear         - one-cycle registered pulse after a clear press
//   running       - high while in RUN
import stopwatch_pkg::*;

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_stop,
    input  logic btn_clear,
    output logic start_resume,
    output logic stop,
    output logic clear,
    output logic running
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic start_press, stop_press, clear_press;
    logic start_take, stop_take;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          clear_q, clear_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .reset(reset), .btn_raw(btn_start), .press(start_press)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .clk(clk), .reset(reset), .btn_raw(btn_stop), .press(stop_press)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk(clk), .reset(reset), .btn_raw(btn_clear), .press(clear_press)
    );

    // Priority clear > stop > start: lower presses in the same cycle are dropped.
    assign stop_take  = stop_press  & ~clear_press;
    assign start_take = start_press & ~stop_press & ~clear_press;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        clear_d = 1'b0;
        if (clear_press) begin
            state_d = ST_IDLE;
            presc_d = '0;
            clear_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (start_take) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stop_take) begin
                        // Prescaler holds so resume finishes the partial interval.
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_take) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            clear_q <= clear_d;
        end
    end

    assign start_resume = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign stop         = (state_q == ST_PAUSE);
    assign running      = (state_q == ST_RUN);
    assign clear        = clear_q;

endmodule
